// File: rtl/clk_en_pkg.sv
// clk_en_gen shared types: FSM states, lost-counter width, counter sizing.
// Optional lost-lock counter is enabled with CLK_EN_LOST_CNT_EN.
package clk_en_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK,
    STABLE,
    RUN,
    LOST
  } state_e;

  localparam int LOST_CNT_W = 8;

  function automatic int cnt_w(input int stable);
    return (stable < 2) ? 1 : $clog2(stable);
  endfunction

endpackage

// File: rtl/clk_en_acc.sv
// One clock-enable channel: increment register, phase accumulator,
// and carry-out registered as a single-cycle enable pulse.
module clk_en_acc
  import clk_en_pkg::*;
#(
  parameter int          ACC_W     = 24,
  parameter int unsigned INC_RESET = 0
) (
  input  logic             clkin,
  input  logic             rst_n,
  input  logic             run,
  input  logic [ACC_W-1:0] inc,
  input  logic             we,
  output logic             ce
);

  localparam logic [ACC_W-1:0] INC_RST = ACC_W'(INC_RESET);

  logic [ACC_W-1:0] inc_q, inc_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ce_q, ce_d;
  logic [ACC_W:0]   sum;

  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, inc_q};
    acc_d = '0;
    ce_d  = 1'b0;
    inc_d = inc_q;
    if (run) begin
      acc_d = sum[ACC_W-1:0];
      ce_d  = sum[ACC_W];
    end
    // rate change keeps the current phase
    if (we) inc_d = inc;
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      inc_q <= INC_RST;
      acc_q <= '0;
      ce_q  <= 1'b0;
    end else begin
      inc_q <= inc_d;
      acc_q <= acc_d;
      ce_q  <= ce_d;
    end
  end

  assign ce = ce_q;

endmodule

// File: rtl/clk_en_gen.sv
// Multi-channel fractional clock-enable generator with PLL lock supervision.
// Define CLK_EN_LOST_CNT_EN to build the saturating lock-loss counter.
module clk_en_gen
  import clk_en_pkg::*;
#(
  parameter int          NUM_CH      = 2,
  parameter int          ACC_W       = 24,
  parameter int          LOCK_STABLE = 1024,
  parameter int unsigned INC_RESET   = 0
) (
  input  logic                    clkin,
  input  logic                    rst_n,
  input  logic                    lock,
  input  logic [NUM_CH*ACC_W-1:0] inc_i,
  input  logic [NUM_CH-1:0]       inc_we,
  output logic [NUM_CH-1:0]       ce_o,
  output logic                    rst_out_n,
  output logic                    ready,
  output logic [LOST_CNT_W-1:0]   lost_cnt
);

  localparam int CW = cnt_w(LOCK_STABLE);
  localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_STABLE - 1);

  logic          sync1_q, lock_s_q;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ready_q, rst_out_q;
  logic          run;

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      WAIT_LOCK: begin
        if (lock_s_q) state_d = STABLE;
      end
      STABLE: begin
        if (!lock_s_q) state_d = WAIT_LOCK;
        else if (cnt_q == CNT_LAST) state_d = RUN;
        else cnt_d = cnt_q + 1'b1;
      end
      RUN: begin
        if (!lock_s_q) state_d = LOST;
      end
      LOST: state_d = WAIT_LOCK;
      default: state_d = WAIT_LOCK;
    endcase
  end

  // accumulate only on edges that stay in RUN so ce drops as RUN is left
  assign run = (state_q == RUN) && (state_d == RUN);

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      lock_s_q  <= 1'b0;
      state_q   <= WAIT_LOCK;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      rst_out_q <= 1'b0;
    end else begin
      sync1_q   <= lock;
      lock_s_q  <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ready_q   <= (state_d == RUN);
      rst_out_q <= (state_d == RUN);
    end
  end

  assign ready     = ready_q;
  assign rst_out_n = rst_out_q;

`ifdef CLK_EN_LOST_CNT_EN
  logic [LOST_CNT_W-1:0] lost_q, lost_d;

  always_comb begin
    lost_d = lost_q;
    if ((state_d == LOST) && (lost_q != '1)) lost_d = lost_q + 1'b1;
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) lost_q <= '0;
    else        lost_q <= lost_d;
  end

  assign lost_cnt = lost_q;
`else
  assign lost_cnt = '0;
`endif

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    clk_en_acc #(
      .ACC_W     (ACC_W),
      .INC_RESET (INC_RESET)
    ) u_acc (
      .clkin (clkin),
      .rst_n (rst_n),
      .run   (run),
      .inc   (inc_i[k*ACC_W +: ACC_W]),
      .we    (inc_we[k]),
      .ce    (ce_o[k])
    );
  end

endmodule

// File: tb/tb_clk_en_gen.sv
// Testbench for clk_en_gen: directed steps plus random lock/write traffic
// checked every cycle against a rule-level reference model.
module tb_clk_en_gen;

  localparam int NUM_CH = 2;
  localparam int ACC_W  = 8;
  localparam int LS     = 16;
  localparam int MOD    = 1 << ACC_W;

  logic                    clkin = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    lock  = 1'b0;
  logic [NUM_CH*ACC_W-1:0] inc_i = '0;
  logic [NUM_CH-1:0]       inc_we = '0;
  logic [NUM_CH-1:0]       ce_o;
  logic                    rst_out_n;
  logic                    ready;
  logic [7:0]              lost_cnt;

  clk_en_gen #(
    .NUM_CH      (NUM_CH),
    .ACC_W       (ACC_W),
    .LOCK_STABLE (LS),
    .INC_RESET   (0)
  ) dut (
    .clkin     (clkin),
    .rst_n     (rst_n),
    .lock      (lock),
    .inc_i     (inc_i),
    .inc_we    (inc_we),
    .ce_o      (ce_o),
    .rst_out_n (rst_out_n),
    .ready     (ready),
    .lost_cnt  (lost_cnt)
  );

  always #5 clkin = ~clkin;

  int vecs = 0;
  int errs = 0;

  // reference model: lock pipeline, qualification streak, phases
  bit              m_s1, m_s2, m_run, m_lost;
  int              m_streak, m_lcnt;
  int              m_phase[NUM_CH];
  int              m_inc[NUM_CH];
  bit [NUM_CH-1:0] m_ce;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_lost();
`ifdef CLK_EN_LOST_CNT_EN
    return m_lcnt;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_run = 0; m_lost = 0;
    m_streak = 0; m_lcnt = 0; m_ce = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      m_phase[k] = 0;
      m_inc[k]   = 0;
    end
  endtask

  task automatic model_edge();
    bit ls, was_run;
    int s;
    ls = m_s2;
    m_s2 = m_s1;
    m_s1 = lock;
    was_run = m_run;
    if (m_lost) begin
      m_lost = 0;
      m_streak = 0;
    end else if (m_run) begin
      if (!ls) begin
        m_run = 0;
        m_lost = 1;
        if (m_lcnt < 255) m_lcnt++;
      end
    end else begin
      m_streak = ls ? m_streak + 1 : 0;
      if (m_streak == LS + 1) begin
        m_run = 1;
        m_streak = 0;
      end
    end
    for (int k = 0; k < NUM_CH; k++) begin
      if (was_run && m_run) begin
        s = m_phase[k] + m_inc[k];
        m_ce[k] = (s >= MOD);
        m_phase[k] = s % MOD;
      end else begin
        m_phase[k] = 0;
        m_ce[k] = 0;
      end
    end
    for (int k = 0; k < NUM_CH; k++)
      if (inc_we[k]) m_inc[k] = int'(inc_i[k*ACC_W +: ACC_W]);
  endtask

  task automatic step();
    @(posedge clkin);
    model_edge();
    #1;
    check("ce_o", 32'(ce_o), 32'(m_ce));
    check("ready", 32'(ready), 32'(m_run));
    check("rst_out_n", 32'(rst_out_n), 32'(m_run));
    check("lost_cnt", 32'(lost_cnt), exp_lost());
    inc_we = '0;
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_inc(int k, int v);
    inc_i[k*ACC_W +: ACC_W] = ACC_W'(v);
    inc_we[k] = 1'b1;
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_ce_o", 32'(ce_o), 0);
    check("rst_ready", 32'(ready), 0);
    check("rst_out_n", 32'(rst_out_n), 0);
    check("rst_lost_cnt", 32'(lost_cnt), 0);
    model_reset();
    #2;
    rst_n = 1'b1;
  endtask

  int n;
  int c;

  initial begin
    model_reset();
    #12;
    check("reset_ce_o", 32'(ce_o), 0);
    check("reset_ready", 32'(ready), 0);
    check("reset_rst_out_n", 32'(rst_out_n), 0);
    check("reset_lost_cnt", 32'(lost_cnt), 0);
    rst_n = 1'b1;

    // qualification latency and first pulse
    set_inc(0, 'h40);
    set_inc(1, 'h40);
    step();
    lock = 1'b1;
    n = 0;
    do begin step(); n++; end while (!ready && n < 60);
    check("lock_latency", n, 19);
    n = 0;
    do begin step(); n++; end while (!ce_o[0] && n < 20);
    check("first_ce_edge", n, 4);
    steps(12);

    // lock loss in RUN
    lock = 1'b0;
    n = 0;
    do begin step(); n++; end while (ready && n < 10);
    check("loss_latency", n, 3);
    steps(5);

    // glitch during STABLE restarts qualification
    lock = 1'b1;
    steps(10);
    lock = 1'b0;
    steps(20);
    lock = 1'b1;
    steps(25);
    check("requalified", 32'(ready), 1);

    // phase-continuous rate change on ch0
    set_inc(0, 'h80);
    steps(20);

    // inc = 0: no pulses
    set_inc(0, 0);
    set_inc(1, 0);
    steps(2);
    c = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (ce_o != '0) c++;
    end
    check("zero_inc_pulses", c, 0);

    // inc = max: 255 of 256 cycles
    set_inc(0, 'hFF);
    steps(2);
    c = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      if (ce_o[0]) c++;
    end
    check("max_inc_pulses", c, 255);

    // write on the edge that leaves RUN is kept
    lock = 1'b0;
    steps(2);
    set_inc(1, 'h20);
    step();
    lock = 1'b1;
    steps(40);

    // many losses saturate the counter
    for (int i = 0; i < 300; i++) begin
      lock = 1'b0;
      steps(4);
      lock = 1'b1;
      steps(22);
    end
    check("lost_sat", 32'(lost_cnt), exp_lost());

    // random lock activity and increment writes
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 49) == 0) lock = ~lock;
      for (int k = 0; k < NUM_CH; k++)
        if ($urandom_range(0, 19) == 0) set_inc(k, int'($urandom_range(0, MOD - 1)));
      step();
    end

    // async reset mid-RUN with ce active
    lock = 1'b1;
    set_inc(0, 'hFF);
    steps(40);
    check("pre_reset_run", 32'(ready), 1);
    async_reset();
    steps(30);
    check("post_reset_run", 32'(ready), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
